// File: rtl/gray_threshold_if.sv
// Pixel input stream for gray_threshold: RGB components with a valid/ready handshake.
interface gray_threshold_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;

  modport master (output in_valid, output r, output g, output b, input in_ready);
  modport slave  (input in_valid, input r, input g, input b, output in_ready);
endinterface

// File: rtl/gray_threshold.sv
// RGB-to-1bpp converter: luma against a per-frame threshold, two-stage pipeline,
// frame-armed input acceptance and pixel position tracking for the line buffer.
module gray_threshold #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter bit INVERT = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                thr,
  gray_threshold_if.slave           pix,
  output logic                      d_out,
  output logic                      ena_out,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int FRAME = WIDTH * HEIGHT;
  localparam int PW    = $clog2(FRAME);
  localparam int CW    = $clog2(WIDTH);
  localparam int RW    = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     thr_q, thr_d;
  logic [PW-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic           vld_p1_q;
  logic [15:0]    sum_p1_q;
  logic           d_out_p2_q;
  logic           vld_p2_q;
  logic           transfer;
  logic           last_pix;

  function automatic logic [15:0] luma(input logic [7:0] rv, input logic [7:0] gv,
                                       input logic [7:0] bv);
    return 16'd77 * {8'd0, rv} + 16'd150 * {8'd0, gv} + 16'd29 * {8'd0, bv};
  endfunction

  function automatic logic binarize(input logic [15:0] sum, input logic [7:0] t);
    return (sum[15:8] >= t) ^ INVERT;
  endfunction

  assign pix.in_ready = (state_q == RUN);
  assign transfer     = pix.in_valid & pix.in_ready;
  assign last_pix     = transfer && (pix_cnt_q == PW'(FRAME - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_pix) state_d = FLUSH;
      FLUSH:   if (!vld_p1_q && !vld_p2_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame arming, accepted-pixel count and output position of the bit on d_out.
  always_comb begin
    thr_d     = thr_q;
    pix_cnt_d = pix_cnt_q;
    col_d     = col_q;
    row_d     = row_q;
    if (state_q == IDLE && start) begin
      thr_d     = thr;
      pix_cnt_d = '0;
      col_d     = '0;
      row_d     = '0;
    end
    if (transfer) begin
      pix_cnt_d = last_pix ? '0 : pix_cnt_q + PW'(1);
    end
    if (vld_p2_q) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      thr_q      <= '0;
      pix_cnt_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      d_out_p2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      pix_cnt_q  <= pix_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      // stage 1 -> stage 2 boundary
      vld_p1_q   <= transfer;
      vld_p2_q   <= vld_p1_q;
      if (vld_p1_q) d_out_p2_q <= binarize(sum_p1_q, thr_q);
    end
  end

  // stage 1: luma sum, data only, qualified by vld_p1_q
  always_ff @(posedge clk) begin
    if (transfer) sum_p1_q <= luma(pix.r, pix.g, pix.b);
  end

  assign d_out      = d_out_p2_q;
  assign ena_out    = vld_p2_q;
  assign col        = col_q;
  assign row        = row_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_gray_threshold.sv
// Randomized scoreboard bench for gray_threshold on a reduced frame, normal and inverted builds.
`timescale 1ns/1ps
module tb_gray_threshold;
  localparam int W     = 16;
  localparam int H     = 6;
  localparam int FRAME = W * H;
  localparam int CW    = $clog2(W);
  localparam int RW    = $clog2(H);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    thr;
  logic          d_out, ena_out, busy, frame_done;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          d_out_i, ena_out_i, busy_i, frame_done_i;
  logic [CW-1:0] col_i;
  logic [RW-1:0] row_i;

  gray_threshold_if pix();
  gray_threshold_if pix_i();

  assign pix_i.in_valid = pix.in_valid;
  assign pix_i.r        = pix.r;
  assign pix_i.g        = pix.g;
  assign pix_i.b        = pix.b;

  gray_threshold #(.WIDTH(W), .HEIGHT(H), .INVERT(1'b0)) dut (
    .clk(clk), .rst(rst_n), .start(start), .thr(thr), .pix(pix),
    .d_out(d_out), .ena_out(ena_out), .col(col), .row(row),
    .busy(busy), .frame_done(frame_done)
  );

  gray_threshold #(.WIDTH(W), .HEIGHT(H), .INVERT(1'b1)) dut_inv (
    .clk(clk), .rst(rst_n), .start(start), .thr(thr), .pix(pix_i),
    .d_out(d_out_i), .ena_out(ena_out_i), .col(col_i), .row(row_i),
    .busy(busy_i), .frame_done(frame_done_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic bv;
    int   c;
    int   r;
    int   t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: luma is the integer part of the weighted sum divided by 256.
  function automatic logic ref_bit(input int rv, input int gv, input int bv, input int t);
    int gray;
    gray = (77 * rv + 150 * gv + 29 * bv) / 256;
    return (gray >= t);
  endfunction

  task automatic pick(input int mode, input int k, output int rv, output int gv, output int bv);
    rv = $urandom_range(0, 255);
    gv = $urandom_range(0, 255);
    bv = $urandom_range(0, 255);
    if (mode == 0 && k < 10) begin
      rv = 255; gv = 255; bv = 255;
    end else if (mode == 0 && k < 20) begin
      rv = 0; gv = 0; bv = 0;
    end else if (mode == 1 && k < 20) begin
      rv = (k % 2 == 0) ? 128 : 127; gv = rv; bv = rv;
    end else if (mode == 2 && k < 5) begin
      rv = 200; gv = 100; bv = 50;
    end
  endtask

  task automatic do_start(input int t);
    thr   = 8'(t);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("in_ready_after_start", pix.in_ready, 1);
  endtask

  // Drives n accepted pixels; at pixel disturb_k pulses start and changes thr.
  task automatic run_frame(input int t, input int mode, input int gap_pct, input int n,
                           input int disturb_k);
    int  k, budget, rv, gv, bv;
    bit  v;
    k = 0;
    budget = 0;
    do_start(t);
    while (k < n && budget < 20 * FRAME) begin
      v = (k < 20) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
      pick(mode, k, rv, gv, bv);
      pix.in_valid = v;
      pix.r = 8'(rv);
      pix.g = 8'(gv);
      pix.b = 8'(bv);
      start = (k == disturb_k);
      thr   = (disturb_k >= 0 && k >= disturb_k) ? 8'(255 - t) : 8'(t);
      if (v && pix.in_ready) begin
        q.push_back('{bv: ref_bit(rv, gv, bv, t), c: k % W, r: (k / W) % H, t: cyc + 2});
        k++;
      end
      @(posedge clk); #1;
      budget++;
    end
    pix.in_valid = 1'b0;
    start = 1'b0;
    check("frame_pixels_accepted", k, n);
  endtask

  task automatic finish_frame();
    int d0, w;
    d0 = done_cnt;
    check("in_ready_drop", pix.in_ready, 0);
    repeat (3) begin
      pix.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    pix.in_valid = 1'b0;
    w = 0;
    while (done_cnt == d0 && w < 12) begin
      @(posedge clk); #1;
      w++;
    end
    check("frame_done_seen", done_cnt, d0 + 1);
    repeat (4) @(posedge clk);
    #1;
    check("single_frame_done", done_cnt, d0 + 1);
    check("busy_idle", busy, 0);
    check("busy_idle_inv", busy_i, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, pix.in_ready, 0);
    check({tag, "_d_out"}, d_out, 0);
    check({tag, "_ena_out"}, ena_out, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_col"}, col, 0);
    check({tag, "_row"}, row, 0);
    check({tag, "_d_out_inv"}, d_out_i, 0);
    check({tag, "_ena_out_inv"}, ena_out_i, 0);
  endtask

  // Monitor: pops an expectation for every ena_out and audits frame_done.
  int   ena_n = 0;
  int   since = 100;
  logic last_d = 1'b0;
  exp_t e;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ena_n  = 0;
        since  = 100;
        last_d = 1'b0;
      end else begin
        check("ena_inv_match", ena_out_i, ena_out);
        check("in_ready_inv_match", pix_i.in_ready, pix.in_ready);
        if (ena_out) begin
          check("ena_expected", q.size() > 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("d_out", d_out, e.bv);
            check("d_out_inv", d_out_i, !e.bv);
            check("col", col, e.c);
            check("row", row, e.r);
            check("latency_cycle", cyc, e.t);
            last_d = e.bv;
          end
          ena_n++;
          since = 0;
        end else begin
          check("d_out_hold", d_out, last_d);
          since++;
        end
        check("frame_done_inv_match", frame_done_i, frame_done);
        if (frame_done) begin
          done_cnt++;
          check("ena_pulses_per_frame", ena_n, FRAME);
          check("frame_done_gap_ok", (since >= 1 && since <= 2), 1);
          check("queue_empty_at_done", q.size(), 0);
          ena_n = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    thr   = 8'd0;
    pix.in_valid = 1'b0;
    pix.r = 8'd0;
    pix.g = 8'd0;
    pix.b = 8'd0;
    #22;
    check_all_zero("reset");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;

    repeat (5) begin
      pix.in_valid = 1'b1;
      pix.r = 8'($urandom_range(0, 255));
      check("idle_in_ready", pix.in_ready, 0);
      check("idle_busy", busy, 0);
      @(posedge clk); #1;
    end
    pix.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    run_frame(200, 0, 30, FRAME, 50);
    finish_frame();
    run_frame(128, 1, 40, FRAME, -1);
    finish_frame();
    run_frame(120, 2, 50, FRAME, -1);
    finish_frame();

    d0 = done_cnt;
    run_frame(90, 3, 20, 40, -1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_after_abort", done_cnt, d0);

    run_frame(60, 3, 25, FRAME, 30);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
